// File: rtl/tlb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tlb_op_sequencer
//   Turns one TLB maintenance instruction from execute (TLBSRCH, TLBRD, TLBWR,
//   TLBFILL, INVTLB) into the TLB unit's CSR-side strobes. It then reports a
//   one-cycle completion to CSR/writeback.
//
//   Any op that modifies the TLB (WR/FILL/INV) first waits in QUIESCE until no
//   translation is in flight. A flush can abandon the op only while it waits
//   there. After that point the op always runs to completion.
//
//   Ports
//     clk, rst            clock; asynchronous active-low reset
//     op_valid/op_ready   request handshake (one op in flight, no back-to-back)
//     op_type/op_inv_op   op code (0 SRCH,1 RD,2 WR,3 FILL,4 INV) / INVTLB op
//     csr_index           TLBIDX.index for RD and WR
//     flush               pipeline flush; honoured only while quiescing
//     mem_quiesce         no fetch / load-store translation outstanding
//     tlb_srch_*          search result from the TLB
//     tlb_suggest_index   an invalid entry, used when tlb_has_free=1
//     tlb_has_free        at least one entry is invalid
//     tlb_rd_index        read port index (held from accept of RD)
//     tlb_wrenable/_index one-cycle write strobe and target entry
//     tlb_invtlb_*        one-cycle invalidate strobe and its op
//     done_*              completion pulse and result fields
//     exc_ine             reserved op / INVTLB op > 6, valid with done_valid
//     refetch_req         TLB was modified, refetch from next PC
// -----------------------------------------------------------------------------
module tlb_op_sequencer #(
  parameter int TLBNUM          = 16,
  parameter int TLB_INDEX_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op_type,
  input  logic [4:0]                 op_inv_op,
  input  logic [TLB_INDEX_WIDTH-1:0] csr_index,
  input  logic                       flush,
  input  logic                       mem_quiesce,
  input  logic                       tlb_srch_e,
  input  logic [TLB_INDEX_WIDTH-1:0] tlb_srch_index,
  input  logic [TLB_INDEX_WIDTH-1:0] tlb_suggest_index,
  input  logic                       tlb_has_free,
  output logic [TLB_INDEX_WIDTH-1:0] tlb_rd_index,
  output logic                       tlb_wrenable,
  output logic [TLB_INDEX_WIDTH-1:0] tlb_wr_index,
  output logic                       tlb_invtlb_valid,
  output logic [4:0]                 tlb_invtlb_op,
  output logic                       done_valid,
  output logic [2:0]                 done_type,
  output logic                       done_srch_hit,
  output logic [TLB_INDEX_WIDTH-1:0] done_index,
  output logic                       done_rd_load,
  output logic                       exc_ine,
  output logic                       refetch_req
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_QUIESCE, S_EXEC, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]                 typ;
    logic [4:0]                 inv_op;
    logic [TLB_INDEX_WIDTH-1:0] index;
    logic                       exc;
  } req_t;

  state_t                     state, state_nxt;
  req_t                       req_q;
  logic [TLB_INDEX_WIDTH-1:0] fill_ptr;
  logic [TLB_INDEX_WIDTH-1:0] fill_idx;
  logic [TLB_INDEX_WIDTH-1:0] rd_index_q;
  logic [TLB_INDEX_WIDTH-1:0] done_index_q;
  logic                       srch_hit_q;
  logic [2:0]                 done_type_q;
  logic                       op_illegal;
  logic                       op_modifies;
  logic                       req_modifies;
  logic                       accept;

  assign accept       = (state == S_IDLE) && op_valid;
  assign op_illegal   = (op_type > OP_INV) || ((op_type == OP_INV) && (op_inv_op > 5'd6));
  assign op_modifies  = (op_type == OP_WR) || (op_type == OP_FILL) || (op_type == OP_INV);
  assign req_modifies = (req_q.typ == OP_WR) || (req_q.typ == OP_FILL) || (req_q.typ == OP_INV);

  // Prefer an invalid entry; otherwise replace round-robin.
  assign fill_idx = tlb_has_free ? tlb_suggest_index : fill_ptr;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (op_valid) begin
          if (op_illegal)       state_nxt = S_DONE;
          else if (op_modifies) state_nxt = S_QUIESCE;
          else                  state_nxt = S_EXEC;
        end
      end
      // A flush wins over mem_quiesce. Nothing has touched the TLB yet.
      S_QUIESCE: begin
        if (flush)            state_nxt = S_IDLE;
        else if (mem_quiesce) state_nxt = S_EXEC;
      end
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured request, FILL pointer and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q        <= '0;
      fill_ptr     <= '0;
      rd_index_q   <= '0;
      done_index_q <= '0;
      srch_hit_q   <= 1'b0;
      done_type_q  <= '0;
    end else begin
      if (accept) begin
        req_q.typ    <= op_type;
        req_q.inv_op <= op_inv_op;
        req_q.index  <= csr_index;
        req_q.exc    <= op_illegal;
        // The read port sees the index from EXEC onward and holds it through DONE.
        if (op_type == OP_RD) rd_index_q <= csr_index;
        if (op_illegal)       done_type_q <= op_type;
      end
      if (state == S_EXEC) begin
        done_type_q <= req_q.typ;
        if (req_q.typ == OP_SRCH) begin
          srch_hit_q   <= tlb_srch_e;
          done_index_q <= tlb_srch_index;
        end
        if (req_q.typ == OP_FILL) begin
          done_index_q <= fill_idx;
          if (!tlb_has_free)
            fill_ptr <= (fill_ptr == TLB_INDEX_WIDTH'(TLBNUM - 1)) ? '0 : fill_ptr + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign op_ready         = (state == S_IDLE);
  assign tlb_rd_index     = rd_index_q;
  assign tlb_wrenable     = (state == S_EXEC) && ((req_q.typ == OP_WR) || (req_q.typ == OP_FILL));
  assign tlb_wr_index     = (req_q.typ == OP_FILL) ? fill_idx : req_q.index;
  assign tlb_invtlb_valid = (state == S_EXEC) && (req_q.typ == OP_INV);
  assign tlb_invtlb_op    = req_q.inv_op;

  assign done_valid    = (state == S_DONE);
  assign done_type     = done_type_q;
  assign done_srch_hit = srch_hit_q;
  assign done_index    = done_index_q;
  assign done_rd_load  = (state == S_DONE) && !req_q.exc && (req_q.typ == OP_RD);
  assign exc_ine       = (state == S_DONE) && req_q.exc;
  assign refetch_req   = (state == S_DONE) && !req_q.exc && req_modifies;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
module tb_tlb_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid, op_ready;
  logic [2:0] op_type;
  logic [4:0] op_inv_op;
  logic [3:0] csr_index;
  logic       flush, mem_quiesce;
  logic       tlb_srch_e, tlb_has_free;
  logic [3:0] tlb_srch_index, tlb_suggest_index;
  logic [3:0] tlb_rd_index, tlb_wr_index, done_index;
  logic       tlb_wrenable, tlb_invtlb_valid;
  logic [4:0] tlb_invtlb_op;
  logic       done_valid, done_srch_hit, done_rd_load, exc_ine, refetch_req;
  logic [2:0] done_type;

  always #5 clk = ~clk;

  tlb_op_sequencer #(.TLBNUM(16), .TLB_INDEX_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .op_inv_op(op_inv_op), .csr_index(csr_index),
    .flush(flush), .mem_quiesce(mem_quiesce),
    .tlb_srch_e(tlb_srch_e), .tlb_srch_index(tlb_srch_index),
    .tlb_suggest_index(tlb_suggest_index), .tlb_has_free(tlb_has_free),
    .tlb_rd_index(tlb_rd_index), .tlb_wrenable(tlb_wrenable),
    .tlb_wr_index(tlb_wr_index), .tlb_invtlb_valid(tlb_invtlb_valid),
    .tlb_invtlb_op(tlb_invtlb_op), .done_valid(done_valid),
    .done_type(done_type), .done_srch_hit(done_srch_hit),
    .done_index(done_index), .done_rd_load(done_rd_load),
    .exc_ine(exc_ine), .refetch_req(refetch_req)
  );

  typedef struct {
    int         cyc;
    logic [2:0] typ;
    logic       exc, refetch, rdload, hit;
    logic [3:0] idx, rd_idx;
    bit         chk_hit, chk_idx, chk_rd;
  } done_t;

  typedef struct {
    int         cyc;
    bit         inv;
    logic [3:0] idx;
    logic [4:0] op;
  } strb_t;

  done_t dq[$];
  strb_t sq[$];

  int   cyc = 0;
  int   nchk = 0, nerr = 0;
  int   fill_ptr_m = 0;   // reference round-robin FILL pointer
  logic exp_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: pops expectations whenever the DUT strobes or completes
  // ---------------------------------------------------------------------------
  done_t      md;
  strb_t      ms;
  logic [3:0] prev_rd = 4'd0;

  always @(negedge clk) begin
    if (rst) begin
      chk("op_ready", op_ready, exp_ready);
      chk("strobe_exclusive", tlb_wrenable & tlb_invtlb_valid, 0);
      if (tlb_wrenable || tlb_invtlb_valid) begin
        if (sq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_strobe: wr=%b inv=%b expected none (cycle %0d)",
                   tlb_wrenable, tlb_invtlb_valid, cyc);
        end else begin
          ms = sq.pop_front();
          chk("strobe_cycle", cyc, ms.cyc);
          chk("strobe_kind_inv", tlb_invtlb_valid, ms.inv);
          if (ms.inv) chk("invtlb_op", tlb_invtlb_op, ms.op);
          else        chk("wr_index", tlb_wr_index, ms.idx);
        end
      end
      if (done_valid) begin
        if (dq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_done: type=%0d expected none (cycle %0d)", done_type, cyc);
        end else begin
          md = dq.pop_front();
          chk("done_cycle", cyc, md.cyc);
          chk("done_type", done_type, md.typ);
          chk("exc_ine", exc_ine, md.exc);
          chk("refetch_req", refetch_req, md.refetch);
          chk("done_rd_load", done_rd_load, md.rdload);
          if (md.chk_hit) chk("done_srch_hit", done_srch_hit, md.hit);
          if (md.chk_idx) chk("done_index", done_index, md.idx);
          if (md.chk_rd) begin
            chk("rd_index_done", tlb_rd_index, md.rd_idx);
            chk("rd_index_exec", prev_rd, md.rd_idx);
          end
        end
      end else begin
        chk("stray_done_flags", {exc_ine, refetch_req, done_rd_load}, 0);
      end
    end
    prev_rd = tlb_rd_index;
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (drive at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic junk_inputs();
    op_valid          = 1'($urandom);
    op_type           = 3'($urandom);
    op_inv_op         = 5'($urandom);
    csr_index         = 4'($urandom);
    mem_quiesce       = 1'($urandom);
    tlb_srch_e        = 1'($urandom);
    tlb_srch_index    = 4'($urandom);
    tlb_suggest_index = 4'($urandom);
    tlb_has_free      = 1'($urandom);
  endtask

  task automatic step_busy();
    @(posedge clk); #1;
    junk_inputs();
    flush     = 1'($urandom);
    exp_ready = 1'b0;
  endtask

  task automatic step_idle();
    @(posedge clk); #1;
    junk_inputs();
    op_valid  = 1'b0;
    flush     = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wrenable", tlb_wrenable, 0);
    chk("rst_invtlb_valid", tlb_invtlb_valid, 0);
    chk("rst_invtlb_op", tlb_invtlb_op, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_type", done_type, 0);
    chk("rst_done_srch_hit", done_srch_hit, 0);
    chk("rst_done_index", done_index, 0);
    chk("rst_done_rd_load", done_rd_load, 0);
    chk("rst_exc_ine", exc_ine, 0);
    chk("rst_refetch_req", refetch_req, 0);
    chk("rst_rd_index", tlb_rd_index, 0);
  endtask

  // Issues one op in a cycle where the sequencer is idle. qwait = number of
  // quiesce cycles seen with mem_quiesce=0 before it rises. flush_at = quiesce
  // cycle in which a flush is pulsed (-1: none). rst_exec = pull reset in EXEC.
  task automatic do_op(input logic [2:0] t, input logic [4:0] iv, input logic [3:0] ix,
                       input int qwait, input int flush_at, input bit rst_exec,
                       input logic se, input logic [3:0] sx,
                       input logic hf, input logic [3:0] sg);
    int    a, e;
    done_t d;
    strb_t s;
    op_valid = 1'b1; op_type = t; op_inv_op = iv; csr_index = ix;
    a = cyc;
    d = '{cyc: 0, typ: t, exc: 1'b0, refetch: 1'b0, rdload: 1'b0, hit: 1'b0,
          idx: 4'd0, rd_idx: 4'd0, chk_hit: 1'b0, chk_idx: 1'b0, chk_rd: 1'b0};
    s = '{cyc: 0, inv: 1'b0, idx: 4'd0, op: 5'd0};
    if (t > 3'd4 || (t == 3'd4 && iv > 5'd6)) begin
      d.cyc = a + 1; d.exc = 1'b1;
      dq.push_back(d);
      step_busy();
      step_idle();
      return;
    end
    if (t <= 3'd1) begin
      step_busy();
      tlb_srch_e = se; tlb_srch_index = sx;
      d.cyc = a + 2;
      if (t == 3'd0) begin
        d.chk_hit = 1'b1; d.chk_idx = 1'b1; d.hit = se; d.idx = sx;
      end else begin
        d.rdload = 1'b1; d.chk_rd = 1'b1; d.rd_idx = ix;
      end
      dq.push_back(d);
      step_busy();
      step_idle();
      return;
    end
    for (int i = 0; i <= qwait; i++) begin
      step_busy();
      flush = 1'b0;
      if (i == flush_at) begin
        flush = 1'b1; mem_quiesce = 1'b0;
        step_idle();
        return;
      end
      mem_quiesce = (i == qwait);
    end
    step_busy();
    e = cyc;
    if (rst_exec) begin
      rst = 1'b0;
      #1;
      chk_reset_outputs();
      fill_ptr_m = 0;
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      rst = 1'b1; exp_ready = 1'b1;
      return;
    end
    tlb_has_free = hf; tlb_suggest_index = sg;
    s.cyc = e;
    if (t == 3'd2) s.idx = ix;
    else if (t == 3'd3) begin
      s.idx = hf ? sg : 4'(fill_ptr_m);
      if (!hf) fill_ptr_m = (fill_ptr_m + 1) % 16;
      d.chk_idx = 1'b1; d.idx = s.idx;
    end else begin
      s.inv = 1'b1; s.op = iv;
    end
    sq.push_back(s);
    d.cyc = e + 1; d.refetch = 1'b1;
    dq.push_back(d);
    step_busy();
    step_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         r, qw, fa;
    logic [2:0] t;
    logic [4:0] iv;
    rst = 1'b0;
    op_valid = 1'b0; op_type = 3'd0; op_inv_op = 5'd0; csr_index = 4'd0;
    flush = 1'b0; mem_quiesce = 1'b0; tlb_srch_e = 1'b0; tlb_srch_index = 4'd0;
    tlb_suggest_index = 4'd0; tlb_has_free = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b1;
    step_idle();

    do_op(3'd0, 5'd0, 4'd0, 0, -1, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0);   // SRCH hit 5
    do_op(3'd2, 5'd0, 4'd9, 2, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);   // WR 9, wait
    repeat (4) do_op(3'd3, 5'd0, 4'd0, 0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    do_op(3'd3, 5'd0, 4'd0, 0, -1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd12);  // free -> 12
    repeat (16) do_op(3'd3, 5'd0, 4'd0, 1, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    do_op(3'd4, 5'd7, 4'd0, 0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);   // bad inv op
    do_op(3'd4, 5'd5, 4'd0, 0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    do_op(3'd3, 5'd0, 4'd0, 3, 1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);    // flushed
    do_op(3'd3, 5'd0, 4'd0, 0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);   // ptr intact
    do_op(3'd2, 5'd0, 4'd6, 1, -1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);   // reset in EXEC
    do_op(3'd3, 5'd0, 4'd0, 0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);   // ptr back to 0
    do_op(3'd1, 5'd0, 4'd3, 0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);   // RD 3
    do_op(3'd6, 5'd0, 4'd0, 0, -1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);   // reserved

    for (int k = 0; k < 300; k++) begin
      r  = int'($urandom % 16);
      t  = (r < 14) ? 3'(r % 5) : 3'(5 + $urandom % 3);
      iv = (($urandom % 8) == 0) ? 5'(7 + $urandom % 25) : 5'($urandom % 7);
      qw = int'($urandom % 5);
      fa = (($urandom % 6) == 0 && qw > 0) ? int'($urandom % qw) : -1;
      do_op(t, iv, 4'($urandom), qw, fa, 1'b0, 1'($urandom), 4'($urandom),
            1'(($urandom % 3) == 0), 4'($urandom));
    end

    repeat (5) step_idle();
    chk("pending_done_empty", dq.size(), 0);
    chk("pending_strobe_empty", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
